// File: rtl/uart_pkg.sv
// Constants shared by the UART transmitter, receiver and transmit FIFO.
// Holds the byte width, the FIFO address width and the launch-state encoding.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int FIFO_ADDR_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } launch_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// System-side write port and transmitter-side launch handshake of the TX FIFO.
// The slave modport is the FIFO itself; master is whoever drives it.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow_tick;
  logic              tx_busy;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_done_tick;

  modport master (
    output wr_en, wr_data, tx_done_tick,
    input  full, empty, level, overflow_tick, tx_busy, tx_start, tx_data
  );

  modport slave (
    input  wr_en, wr_data, tx_done_tick,
    output full, empty, level, overflow_tick, tx_busy, tx_start, tx_data
  );

endinterface

// File: rtl/fifo_mem_2p.sv
// Register array with one synchronous write port and one asynchronous read port.
module fifo_mem_2p
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // NOTE: the array is deliberately not reset; every entry is written before it
  // can be read, so a reset would only add a clear path to each register.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter one frame at a time.
// Pops at launch, then waits for tx_done_tick before launching the next byte.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus
);

  localparam int               LVL_W = ADDR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH = LVL_W'(2 ** ADDR_W);

  launch_state_e     state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              overflow_q, overflow_d;

  logic              full;
  logic              empty;
  logic              wr_accept;
  logic              launch;
  logic [DATA_W-1:0] rd_data;

  assign full      = (level_q == DEPTH);
  assign empty     = (level_q == '0);
  assign wr_accept = bus.wr_en && !full;

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.wr_data),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  // NOTE: every variable gets its default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    overflow_d = bus.wr_en && full;
    launch     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          launch     = 1'b1;
          state_d    = ST_BUSY;
          tx_start_d = 1'b1;
          tx_data_d  = rd_data;
          rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
        end
      end
      ST_BUSY: begin
        if (bus.tx_done_tick) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end

    // A write and a launch in the same cycle cancel out in the level count.
    unique case ({wr_accept, launch})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values,
  // independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.level         = level_q;
  assign bus.overflow_tick = overflow_q;
  assign bus.tx_busy       = (state_q == ST_BUSY);
  assign bus.tx_start      = tx_start_q;
  assign bus.tx_data       = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a behavioural 8N1 transmitter paces launches
// and a line monitor decodes what actually leaves on the serial line.
module tb_uart_tx_fifo;

  localparam int BIT_CLKS = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_fifo_if bus_if ();

  uart_tx_fifo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  int checks = 0;
  int errors = 0;

  // Transmitter model: latches tx_data only when idle, shifts start/8 data/stop.
  logic       tx_hold = 1'b0;
  logic       stray_done = 1'b0;
  logic       m_busy;
  logic       m_done;
  logic [9:0] m_sh;
  int         m_bit;
  int         m_cnt;
  logic       line;

  assign bus_if.tx_done_tick = m_done | stray_done;
  assign line = m_busy ? m_sh[0] : 1'b1;

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (reset) begin
      m_busy <= 1'b0;
      m_bit  <= 0;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (bus_if.tx_start) begin
        m_sh   <= {1'b1, bus_if.tx_data, 1'b0};
        m_busy <= 1'b1;
        m_bit  <= 0;
        m_cnt  <= 0;
      end
    end else if (m_cnt == BIT_CLKS - 1) begin
      m_cnt <= 0;
      if (m_bit == 9) begin
        if (!tx_hold) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
      end else begin
        m_bit <= m_bit + 1;
        m_sh  <= m_sh >> 1;
      end
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  // Event counters observed at each clock edge.
  int   cyc = 0;
  int   last_done = -100;
  int   n_start = 0;
  int   n_gap2 = 0;
  int   n_dbl = 0;
  logic start_prev = 1'b0;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    start_prev <= bus_if.tx_start;
    if (bus_if.tx_done_tick) last_done <= cyc;
    if (bus_if.tx_start) begin
      n_start <= n_start + 1;
      if (cyc - last_done == 2) n_gap2 <= n_gap2 + 1;
      if (start_prev) n_dbl <= n_dbl + 1;
    end
  end

  // Line monitor: mid-bit sampling of LSB-first 8N1 frames.
  logic [7:0] rx_q[$];
  int         frame_err = 0;

  initial begin : line_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && line === 1'b0) begin
        repeat (BIT_CLKS / 2 - 1) @(negedge clk);
        if (line !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CLKS) @(negedge clk);
          b[i] = line;
        end
        repeat (BIT_CLKS) @(negedge clk);
        if (line !== 1'b1) frame_err++;
        rx_q.push_back(b);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (bus_if.tx_done_tick !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_done_seen"}, 32'(bus_if.tx_done_tick), 32'd1);
  endtask

  task automatic wait_rx(input string tag, input int count, input int budget);
    int n = 0;
    while (rx_q.size() < count && n < budget) begin
      step();
      n++;
    end
    check({tag, "_rx_count"}, 32'(rx_q.size()), 32'(count));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((bus_if.tx_busy !== 1'b0 || bus_if.empty !== 1'b1) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_idle"}, 32'(bus_if.tx_busy), 32'd0);
  endtask

  task automatic check_rx(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    check(tag, 32'(got), 32'(exp));
  endtask

  initial begin
    logic [7:0] exp_q[$];
    int snap_start, snap_gap, k;

    bus_if.wr_en   = 1'b0;
    bus_if.wr_data = '0;

    // Reset state
    step(); step();
    check("rst_empty",    32'(bus_if.empty),         32'd1);
    check("rst_full",     32'(bus_if.full),          32'd0);
    check("rst_level",    32'(bus_if.level),         32'd0);
    check("rst_tx_start", 32'(bus_if.tx_start),      32'd0);
    check("rst_tx_busy",  32'(bus_if.tx_busy),       32'd0);
    check("rst_overflow", 32'(bus_if.overflow_tick), 32'd0);
    check("rst_tx_data",  32'(bus_if.tx_data),       32'd0);
    reset = 1'b0;
    step();

    // 1: single byte, launch latency N+2
    bus_if.wr_en = 1'b1; bus_if.wr_data = 8'hA5;
    step();
    bus_if.wr_en = 1'b0;
    check("t1_level_n1",    32'(bus_if.level),    32'd1);
    check("t1_start_n1",    32'(bus_if.tx_start), 32'd0);
    step();
    check("t1_start_n2",    32'(bus_if.tx_start), 32'd1);
    check("t1_data_n2",     32'(bus_if.tx_data),  32'hA5);
    check("t1_empty_n2",    32'(bus_if.empty),    32'd1);
    step();
    check("t1_start_n3",    32'(bus_if.tx_start), 32'd0);
    check("t1_busy_n3",     32'(bus_if.tx_busy),  32'd1);
    wait_done("t1", 200);
    step();
    check("t1_busy_after",  32'(bus_if.tx_busy),  32'd0);
    check("t1_empty_after", 32'(bus_if.empty),    32'd1);
    wait_rx("t1", 1, 100);
    check_rx("t1_line_byte", 8'hA5);

    // 2: burst of 16, level tracking and 2-cycle inter-frame gap
    snap_start = n_start;
    snap_gap   = n_gap2;
    for (int i = 0; i < 16; i++) begin
      bus_if.wr_en = 1'b1; bus_if.wr_data = 8'(i);
      step();
      check($sformatf("t2_level_%0d", i), 32'(bus_if.level), (i == 0) ? 32'd1 : 32'(i));
    end
    bus_if.wr_en = 1'b0;
    check("t2_full_end", 32'(bus_if.full), 32'd0);
    wait_done("t2_first", 200);
    step(); step();
    check("t2_gap_start", 32'(bus_if.tx_start), 32'd1);
    check("t2_gap_data",  32'(bus_if.tx_data),  32'h01);
    check("t2_gap_level", 32'(bus_if.level),    32'd14);
    wait_rx("t2", 16, 2000);
    for (int i = 0; i < 16; i++) check_rx($sformatf("t2_line_%0d", i), 8'(i));
    wait_idle("t2", 200);
    check("t2_starts", 32'(n_start - snap_start), 32'd16);
    check("t2_gap2",   32'(n_gap2 - snap_gap),    32'd15);

    // 3: transmitter held, fill to 16, then overflow write
    tx_hold = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus_if.wr_en = 1'b1; bus_if.wr_data = 8'(8'h80 + i);
      step();
    end
    bus_if.wr_en = 1'b0;
    check("t3_level_full", 32'(bus_if.level), 32'd16);
    check("t3_full",       32'(bus_if.full),  32'd1);
    bus_if.wr_en = 1'b1; bus_if.wr_data = 8'hEE;
    step();
    bus_if.wr_en = 1'b0;
    check("t3_ovf_pulse",  32'(bus_if.overflow_tick), 32'd1);
    check("t3_ovf_level",  32'(bus_if.level),         32'd16);
    step();
    check("t3_ovf_clear",  32'(bus_if.overflow_tick), 32'd0);
    check("t3_level_hold", 32'(bus_if.level),         32'd16);

    // 4: write in the launch cycle at level 16 is rejected
    tx_hold = 1'b0;
    wait_done("t4", 200);
    step();
    check("t4_full_launch_cycle", 32'(bus_if.full), 32'd1);
    bus_if.wr_en = 1'b1; bus_if.wr_data = 8'hDD;
    step();
    bus_if.wr_en = 1'b0;
    check("t4_ovf",   32'(bus_if.overflow_tick), 32'd1);
    check("t4_level", 32'(bus_if.level),         32'd15);
    check("t4_start", 32'(bus_if.tx_start),      32'd1);
    check("t4_data",  32'(bus_if.tx_data),       32'h81);
    wait_rx("t34", 17, 2000);
    for (int i = 0; i < 17; i++) check_rx($sformatf("t34_line_%0d", i), 8'(8'h80 + i));
    wait_idle("t4", 200);

    // 5: 40 bytes across pointer wraps, never overfilling
    for (int i = 0; i < 40; i++) begin
      bus_if.wr_en = 1'b0;
      k = 0;
      while (bus_if.level >= 5'd16 && k < 600) begin
        step();
        k++;
      end
      bus_if.wr_en = 1'b1; bus_if.wr_data = 8'(i * 7 + 3);
      exp_q.push_back(8'(i * 7 + 3));
      step();
      check($sformatf("t5_no_ovf_%0d", i), 32'(bus_if.overflow_tick), 32'd0);
    end
    bus_if.wr_en = 1'b0;
    wait_rx("t5", 40, 4000);
    for (int i = 0; i < 40; i++) check_rx($sformatf("t5_line_%0d", i), exp_q[i]);
    wait_idle("t5", 200);
    check("t5_frame_err", 32'(frame_err), 32'd0);

    // 6: reset mid-frame with 5 queued, stray done, then a clean byte
    for (int i = 0; i < 6; i++) begin
      bus_if.wr_en = 1'b1; bus_if.wr_data = 8'(8'h51 + i);
      step();
    end
    bus_if.wr_en = 1'b0;
    repeat (10) step();
    check("t6_level_pre", 32'(bus_if.level),   32'd5);
    check("t6_busy_pre",  32'(bus_if.tx_busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_level",    32'(bus_if.level),    32'd0);
    check("t6_busy",     32'(bus_if.tx_busy),  32'd0);
    check("t6_start",    32'(bus_if.tx_start), 32'd0);
    check("t6_tx_data",  32'(bus_if.tx_data),  32'd0);
    check("t6_line_idle", 32'(line),           32'd1);
    repeat (60) step();
    rx_q.delete();
    snap_start = n_start;
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    repeat (4) step();
    check("t6_stray_no_launch", 32'(n_start - snap_start), 32'd0);
    check("t6_stray_busy",      32'(bus_if.tx_busy),       32'd0);
    bus_if.wr_en = 1'b1; bus_if.wr_data = 8'h3C;
    step();
    bus_if.wr_en = 1'b0;
    check("t6_new_level", 32'(bus_if.level), 32'd1);
    step();
    check("t6_new_start", 32'(bus_if.tx_start), 32'd1);
    check("t6_new_data",  32'(bus_if.tx_data),  32'h3C);
    wait_rx("t6", 1, 200);
    check_rx("t6_line_byte", 8'h3C);
    wait_idle("t6", 200);
    check("final_frame_err",    32'(frame_err), 32'd0);
    check("final_double_start", 32'(n_dbl),     32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
